// File: rtl/subneg_bus_pkg.sv
// Shared definitions for the subneg memory responder.
// Holds the bus widths, the default I/O-mapped address, the bus state encoding,
// the array write payload and the strobe protocol-violation check.
package subneg_bus_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 8'hFF;

    // Bus phase as observed from the sampled master strobes
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } bus_state_e;

    // One write into the storage array (bus or preload source)
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

    // Illegal strobe combinations: read and write together, or either with le
    function automatic logic proto_violation(input logic le,
                                             input logic oe_n,
                                             input logic we_n);
        return (!oe_n && !we_n) || (le && (!oe_n || !we_n));
    endfunction

endpackage

// File: rtl/subneg_mem_array.sv
// 256x8 storage with one write port and one registered read port.
// Ports:
//   clk, rst_n      - clock, async active-low reset (read register only)
//   wr_en_i, wr_i   - single write port: address/data payload
//   rd_addr_i       - read address, sampled every rising edge
//   rd_ext_sel_i    - when 1 the read register loads rd_ext_data_i instead
//   rd_ext_data_i   - external value that shadows the array on read
//   rd_data_o       - registered read data
// Storage contents are never reset.
module subneg_mem_array
    import subneg_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  mem_wr_t           wr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_ext_sel_i,
    input  logic [DATA_W-1:0] rd_ext_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage write; no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_i.addr] <= wr_i.data;
        end
    end

    // Read mux; a same-edge write is not visible until the following edge
    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
        if (rd_ext_sel_i) begin
            rd_data_d = rd_ext_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/subneg_mem_responder.sv
// Memory responder for the subneg shared bus.
// A master latches an address with le, then reads (oe_n low) or writes
// (we_n low). A preload channel fills the array while the bus is idle.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   le, oe_n, we_n                - master strobes (le high, oe_n/we_n low active)
//   bus_in                        - shared bus as seen by the responder
//   bus_out, bus_oe               - read data and its drive enable (no tristate here)
//   io_in                         - value returned for reads of IO_ADDR
//   ld_valid/ld_addr/ld_data      - preload request, held until ld_ready
//   ld_ready                      - preload accepted on an edge with ld_valid
//   proto_err                     - sticky illegal-strobe flag
//   wr_count                      - completed bus writes, wraps at 255
module subneg_mem_responder
    import subneg_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              le,
    input  logic              oe_n,
    input  logic              we_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] io_in,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              proto_err,
    output logic [DATA_W-1:0] wr_count
);

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              proto_err_q, proto_err_d;
    logic [DATA_W-1:0] wr_count_q, wr_count_d;
    logic              we_n_prev_q, we_n_prev_d;
    logic              run_q;

    logic              bus_wr_c;
    logic              ld_ready_c;
    logic              ld_fire_c;
    logic              arr_wr_en_c;
    mem_wr_t           arr_wr_c;
    logic              io_sel_c;

    // Array writes are held off while in reset and for the first edge after,
    // so a reset that lands during a write aborts it cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Strobe decode; le or oe_n low excludes a bus write, which also covers
    // every protocol-violation combination
    always_comb begin
        bus_wr_c   = run_q && !le && oe_n && !we_n;
        ld_ready_c = run_q && (state_q == IDLE) && !le && oe_n && we_n;
        ld_fire_c  = ld_valid && ld_ready_c;
        io_sel_c   = (addr_q == IO_ADDR);
    end

    // Array write port: bus write has priority over preload
    always_comb begin
        arr_wr_en_c   = bus_wr_c || ld_fire_c;
        arr_wr_c.addr = ld_addr;
        arr_wr_c.data = ld_data;
        if (bus_wr_c) begin
            arr_wr_c.addr = addr_q;
            arr_wr_c.data = bus_in;
        end
    end

    // Next-state for bus phase, address latch, error flag and write counter
    always_comb begin
        state_d     = IDLE;
        addr_d      = addr_q;
        proto_err_d = proto_err_q;
        wr_count_d  = wr_count_q;
        we_n_prev_d = we_n;

        if (le) begin
            state_d = ADDR;
        end else if (!oe_n) begin
            state_d = READ;
        end else if (!we_n) begin
            state_d = WRITE;
        end

        if (le) begin
            addr_d = bus_in;
        end

        if (proto_violation(le, oe_n, we_n)) begin
            proto_err_d = 1'b1;
        end

        // Count only the first written edge of each we_n low pulse
        if (bus_wr_c && we_n_prev_q) begin
            wr_count_d = wr_count_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
            wr_count_q  <= '0;
            we_n_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            proto_err_q <= proto_err_d;
            wr_count_q  <= wr_count_d;
            we_n_prev_q <= we_n_prev_d;
        end
    end

    subneg_mem_array u_mem_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (arr_wr_en_c),
        .wr_i         (arr_wr_c),
        .rd_addr_i    (addr_q),
        .rd_ext_sel_i (io_sel_c),
        .rd_ext_data_i(io_in),
        .rd_data_o    (bus_out)
    );

    assign bus_oe    = !oe_n && !le && we_n;
    assign ld_ready  = ld_ready_c;
    assign proto_err = proto_err_q;
    assign wr_count  = wr_count_q;

endmodule

// File: doc/subneg_mem_responder.md
SUBNEG_MEM_RESPONDER -- requirements
Module: subneg_mem_responder

Interface
REQ-001 SHALL have parameter IO_ADDR, default 8'hFF: address whose reads return io_in instead of the array.
REQ-002 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port le  input  1  address-latch enable from master, active high.
REQ-005 SHALL have port oe_n  input  1  read enable, active low; master releases bus when low.
REQ-006 SHALL have port we_n  input  1  write enable, active low.
REQ-007 SHALL have port bus_in  input  8  shared bus as seen from responder.
REQ-008 SHALL have port bus_out  output  8  read data driven onto bus.
REQ-009 SHALL have port bus_oe  output  1  responder drives bus when 1.
REQ-010 SHALL have port io_in  input  8  external value returned at IO_ADDR.
REQ-011 SHALL have ports ld_valid in 1, ld_addr in 8, ld_data in 8, ld_ready out 1: preload write channel.
REQ-012 SHALL have port proto_err  output  1  sticky protocol-violation flag.
REQ-013 SHALL have port wr_count  output  8  number of completed bus writes, wraps 255->0.

Function
REQ-014 Address register SHALL load bus_in on every rising edge where le==1, and hold while le==0 (sampled transparent latch).
REQ-015 Read-data register SHALL load mem[addr_q] (or io_in when addr_q==IO_ADDR) on every rising edge; valid one cycle after address capture.
REQ-016 bus_oe SHALL equal (oe_n==0 && le==0 && we_n==1), combinational; bus_out SHALL equal the read-data register.
REQ-017 Master timing satisfied: le high 1 cycle, then oe_n low the next cycle; data valid before master samples one edge later.
REQ-018 Bus write SHALL occur on each rising edge with we_n==0 && oe_n==1 && le==0: mem[addr_q] <= bus_in.
REQ-019 Writes to IO_ADDR SHALL be accepted into the array (array cell shadowed on read by io_in).
REQ-020 wr_count SHALL increment once per we_n falling (high-to-low sampled) that causes a write, not per low cycle.
REQ-021 Bus state machine SHALL have states IDLE, ADDR (le==1), READ (oe_n==0), WRITE (we_n==0); transitions follow sampled strobes each cycle, any->ADDR on le==1.
REQ-022 ld_ready SHALL be 1 only in IDLE with le==0, oe_n==1, we_n==1; preload write SHALL occur on an edge with ld_valid && ld_ready, writing mem[ld_addr] <= ld_data.
REQ-023 Bus write SHALL win over preload: ld_ready is 0 whenever any bus strobe is active, so no same-edge conflict.
REQ-024 ld_valid held with ld_ready==0 SHALL stall without loss; ld_addr/ld_data must stay stable until accepted.
REQ-025 proto_err SHALL set on any edge with (oe_n==0 && we_n==0) or (le==1 && (oe_n==0 || we_n==0)); cleared only by reset.
REQ-026 During a proto_err condition no array write SHALL occur and bus_oe SHALL be 0.
REQ-027 Read-during-write same address SHALL return old data on that edge, new data from the next edge.

Reset
REQ-028 On rst_n low (asynchronous): addr_q=0, read-data=0, state=IDLE, proto_err=0, wr_count=0, edge-detect flops=1 (we_n idle); bus_oe follows REQ-016.
REQ-029 Array contents SHALL NOT be reset; preload is the only initialisation path.
REQ-030 Reset asserted mid-write SHALL abort without writing; after release the first edge with we_n low counts as a new falling edge only if we_n was sampled high before it.

Structure
REQ-031 Shared package subneg_bus_pkg SHALL hold bus state enum (IDLE, ADDR, READ, WRITE), data/address width 8, default IO_ADDR.
REQ-032 Sub-module subneg_mem_array SHALL implement 256x8 storage, one write port (muxed bus/preload), one registered read port.
REQ-033 Total RTL SHALL be 120-400 lines; no tristates inside the block (bus_oe exported).

Verification
REQ-034 Preload mem[0..2]={10,11,3}, le=1 bus=0 one cycle, then oe_n=0 -> bus_oe=1, bus_out=10 on the edge after oe_n falls.
REQ-035 le=1 bus=11, le=0, bus=8'h2A, we_n=0 one cycle -> mem[11]=8'h2A, wr_count=1; re-read returns 8'h2A.
REQ-036 io_in=8'h5C, read address 8'hFF -> bus_out=8'h5C; write 8'h77 to FF then read -> still io_in.
REQ-037 oe_n=0 and we_n=0 together -> proto_err=1, bus_oe=0, no array change; stays 1 until rst_n low.
REQ-038 ld_valid held during master read -> ld_ready=0, accepted the first IDLE cycle; we_n held low 3 cycles -> wr_count +1 only.
REQ-039 rst_n pulsed low during we_n low -> no write, wr_count=0, addr_q=0, array preloaded data intact.
